burst_cmd_arbiter: RTL

- Shares the single AXI_memory_master_burst command port between two requesters: memory_writer (frame writes) and a frame reader client (reads).
- Accepts a request from either client and latches its command. Issues a one-cycle start_write or start_read to the master, then waits for completion and returns a one-cycle done to the granted client.
- Round-robin arbitration with a watchdog. Exactly one burst is outstanding at any time.

---
 rtl/axi_mem_pkg.sv | 18 +
 rtl/rr_arbiter2.sv | 21 ++
 rtl/burst_cmd_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/axi_mem_pkg.sv
// Shared definitions for the AXI memory burst command path: FSM states,
// fixed burst attributes and the transaction IDs used by writer and reader.
package axi_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam int WR_ID = 0;
  localparam int RD_ID = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester always wins, and on a tie the
// client that did not win the previous grant is chosen.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_rd,
  output logic       grant_valid,
  output logic       pick_rd
);

  // req[0] is the writer, req[1] the reader; pick_rd is only meaningful with grant_valid
  always_comb begin
    grant_valid = |req;
    pick_rd     = 1'b0;
    if (req == 2'b11) begin
      pick_rd = ~last_rd;
    end else if (req[1]) begin
      pick_rd = 1'b1;
    end
  end

endmodule

// File: rtl/burst_cmd_arbiter.sv
// Shares one AXI burst master command port between a frame writer and a frame
// reader, keeping exactly one burst outstanding and guarding it with a watchdog.
module burst_cmd_arbiter
  import axi_mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [31:0]           wr_len,
  output logic                  wr_done,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [31:0]           rd_len,
  output logic                  rd_done,
  output logic                  start_write,
  output logic                  start_read,
  output logic [ID_WIDTH-1:0]   write_id,
  output logic [ID_WIDTH-1:0]   read_id,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [31:0]           cmd_len,
  output logic [2:0]            cmd_size,
  output logic [1:0]            cmd_burst,
  input  logic                  bvalid_bready,
  input  logic                  rlast_hs,
  output logic                  grant_wr,
  output logic                  timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state;
  state_e           state_next;
  logic             last_rd;
  logic             grant_valid;
  logic             pick_rd;
  logic [CNT_W-1:0] wdog_cnt;
  logic             complete;
  logic             expire;
  logic             unused_len_bits;

  rr_arbiter2 u_rr (
    .req         ({rd_req, wr_req}),
    .last_rd     (last_rd),
    .grant_valid (grant_valid),
    .pick_rd     (pick_rd)
  );

  // Only the granted client's completion counts; the other one is ignored
  assign complete = grant_wr ? bvalid_bready : rlast_hs;
  assign expire   = (wdog_cnt == WDOG_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (complete || expire) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The watchdog clears on grant and counts through ISSUE and WAIT, so done and
  // timeout_err arrive TIMEOUT_CYCLES cycles after the start pulse on expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_wr    <= 1'b0;
      last_rd     <= 1'b1;
      cmd_addr    <= '0;
      cmd_len     <= '0;
      wdog_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            grant_wr <= ~pick_rd;
            cmd_addr <= pick_rd ? rd_addr : wr_addr;
            cmd_len  <= {24'h0, pick_rd ? rd_len[7:0] : wr_len[7:0]};
            wdog_cnt <= '0;
          end
        end
        ISSUE: begin
          wdog_cnt <= wdog_cnt + 1'b1;
        end
        WAIT: begin
          wdog_cnt <= wdog_cnt + 1'b1;
          if (!complete && expire) begin
            timeout_err <= 1'b1;
          end
        end
        DONE: begin
          last_rd  <= ~grant_wr;
          grant_wr <= 1'b0;
        end
        default: begin
          grant_wr <= 1'b0;
        end
      endcase
    end
  end

  assign start_write = (state == ISSUE) &&  grant_wr;
  assign start_read  = (state == ISSUE) && !grant_wr;
  assign wr_done     = (state == DONE)  &&  grant_wr;
  assign rd_done     = (state == DONE)  && !grant_wr;

  assign write_id  = ID_WIDTH'(WR_ID);
  assign read_id   = ID_WIDTH'(RD_ID);
  assign cmd_size  = AXI_SIZE_4B;
  assign cmd_burst = AXI_BURST_INCR;

  assign unused_len_bits = ^{wr_len[31:8], rd_len[31:8]};

endmodule
